// File: rtl/rgbw_scale_sequencer_if.sv
// Multiplier handshake bundle between rgbw_scale_sequencer and the shared 8x8 multiplier.
// The sequencer is the master (drives operands and load strobe); the multiplier is the slave.
interface rgbw_scale_sequencer_if;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_ld;
    logic        mult_rdy;
    logic [15:0] mult_res;

    modport master (
        output mult_a,
        output mult_b,
        output mult_ld,
        input  mult_rdy,
        input  mult_res
    );

    modport slave (
        input  mult_a,
        input  mult_b,
        input  mult_ld,
        output mult_rdy,
        output mult_res
    );
endinterface

// File: rtl/rgbw_scale_sequencer.sv
// rgbw_scale_sequencer: scales the R, G, B and W levels by the intensity byte using one
// shared 8x8 multiplier, then commits all four duties together with a one-cycle done.
// Intensity 0 and 255 bypass the multiplier. A missing multiplier answer aborts the run
// after TIMEOUT enabled cycles and raises the sticky err flag.
// Optional build macro RGBW_SCALE_ROUND_EN: round the product to nearest instead of truncating.
module rgbw_scale_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_half,
    input  logic                          start,
    input  logic [7:0]                    lint,
    input  logic [7:0]                    red_in,
    input  logic [7:0]                    green_in,
    input  logic [7:0]                    blue_in,
    input  logic [7:0]                    white_in,
    rgbw_scale_sequencer_if.master        mult,
    output logic [7:0]                    red_out,
    output logic [7:0]                    green_out,
    output logic [7:0]                    blue_out,
    output logic [7:0]                    white_out,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [1:0]    ch;
    logic [7:0]    lint_q;
    logic [7:0]    red_q;
    logic [7:0]    green_q;
    logic [7:0]    blue_q;
    logic [7:0]    white_q;
    logic [7:0]    shadow_r;
    logic [7:0]    shadow_g;
    logic [7:0]    shadow_b;
    logic          pending;
    logic          commit_bypass;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    next_level;
    logic [7:0]    scaled;

`ifdef RGBW_SCALE_ROUND_EN
    // Round to nearest; lint never exceeds 254 on this path so the sum cannot overflow.
    logic [15:0] rounded_res;
    logic        unused_round_bits;
    assign rounded_res       = mult.mult_res + 16'h0080;
    assign scaled            = rounded_res[15:8];
    assign unused_round_bits = ^rounded_res[7:0];
`else
    // Truncate: the upper byte of the product is the scaled level.
    logic unused_res_bits;
    assign scaled          = mult.mult_res[15:8];
    assign unused_res_bits = ^mult.mult_res[7:0];
`endif

    // Level of the channel that follows the one currently being captured.
    always_comb begin
        next_level = white_q;
        case (ch)
            2'd0:    next_level = green_q;
            2'd1:    next_level = blue_q;
            default: next_level = white_q;
        endcase
    end

    // Run sequencing, multiplier handshake, shadow capture and atomic duty commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ch            <= 2'd0;
            lint_q        <= 8'd0;
            red_q         <= 8'd0;
            green_q       <= 8'd0;
            blue_q        <= 8'd0;
            white_q       <= 8'd0;
            shadow_r      <= 8'd0;
            shadow_g      <= 8'd0;
            shadow_b      <= 8'd0;
            pending       <= 1'b0;
            commit_bypass <= 1'b0;
            tmo_cnt       <= '0;
            mult.mult_a   <= 8'd0;
            mult.mult_b   <= 8'd0;
            mult.mult_ld  <= 1'b0;
            red_out       <= 8'd0;
            green_out     <= 8'd0;
            blue_out      <= 8'd0;
            white_out     <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else if (clk_half) begin
            done <= 1'b0;
            if (start && busy) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (commit_bypass) begin
                        commit_bypass <= 1'b0;
                        if (lint_q == 8'd0) begin
                            red_out   <= 8'd0;
                            green_out <= 8'd0;
                            blue_out  <= 8'd0;
                            white_out <= 8'd0;
                        end else begin
                            red_out   <= red_q;
                            green_out <= green_q;
                            blue_out  <= blue_q;
                            white_out <= white_q;
                        end
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else if (start || pending) begin
                        lint_q  <= lint;
                        red_q   <= red_in;
                        green_q <= green_in;
                        blue_q  <= blue_in;
                        white_q <= white_in;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        ch      <= 2'd0;
                        pending <= 1'b0;
                        if (lint == 8'd0 || lint == 8'hFF) begin
                            commit_bypass <= 1'b1;
                        end else begin
                            state        <= LOAD;
                            mult.mult_ld <= 1'b1;
                            mult.mult_a  <= red_in;
                            mult.mult_b  <= lint;
                        end
                    end
                end
                LOAD: begin
                    mult.mult_ld <= 1'b0;
                    tmo_cnt      <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (mult.mult_rdy) begin
                        case (ch)
                            2'd0:    shadow_r <= scaled;
                            2'd1:    shadow_g <= scaled;
                            2'd2:    shadow_b <= scaled;
                            default: ;
                        endcase
                        if (ch != 2'd3) begin
                            ch           <= ch + 2'd1;
                            state        <= LOAD;
                            mult.mult_ld <= 1'b1;
                            mult.mult_a  <= next_level;
                        end else begin
                            red_out   <= shadow_r;
                            green_out <= shadow_g;
                            blue_out  <= shadow_b;
                            white_out <= scaled;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgbw_scale_sequencer.sv
// Testbench for rgbw_scale_sequencer: behavioural multiplier answering two enabled
// cycles after each load, a vector table for single runs, and hand-written sequences
// for pending restart, timeout, clock-enable toggling and mid-run reset.
module tb_rgbw_scale_sequencer;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_half = 1'b1;
    logic       start = 1'b0;
    logic [7:0] lint = 8'd0;
    logic [7:0] red_in = 8'd0;
    logic [7:0] green_in = 8'd0;
    logic [7:0] blue_in = 8'd0;
    logic [7:0] white_in = 8'd0;
    logic [7:0] red_out;
    logic [7:0] green_out;
    logic [7:0] blue_out;
    logic [7:0] white_out;
    logic       busy;
    logic       done;
    logic       err;

    rgbw_scale_sequencer_if mif ();

    rgbw_scale_sequencer #(.TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_half  (clk_half),
        .start     (start),
        .lint      (lint),
        .red_in    (red_in),
        .green_in  (green_in),
        .blue_in   (blue_in),
        .white_in  (white_in),
        .mult      (mif.master),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out),
        .white_out (white_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [7:0]  lint;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [7:0]  w;
        logic [31:0] exp_trunc;
        logic [31:0] exp_round;
        int          exp_cyc;
        int          exp_lds;
    } vec_t;

    vec_t vecs [6];

    int  tests_run = 0;
    int  tests_failed = 0;
    int  ld_count = 0;
    int  mute_at = -1;
    int  cd = 0;
    bit  toggle_en = 1'b0;
    logic [15:0] prod;

    // Free-running system clock.
    always #5 clk = ~clk;

    // Optional 1/0 toggling of the clock enable, changed away from the active edge.
    always @(negedge clk) begin
        if (toggle_en) clk_half = ~clk_half;
    end

    // Behavioural multiplier: answers L enabled cycles after each load, unless muted.
    always @(posedge clk) begin
        if (!reset) begin
            mif.mult_rdy <= 1'b0;
            mif.mult_res <= 16'd0;
            cd = 0;
        end else if (clk_half) begin
            mif.mult_rdy <= 1'b0;
            if (cd == 1) begin
                mif.mult_rdy <= 1'b1;
                mif.mult_res <= prod;
            end
            if (cd > 0) cd = cd - 1;
            if (mif.mult_ld) begin
                ld_count++;
                if (ld_count != mute_at) begin
                    cd   = L - 1;
                    prod = 16'(mif.mult_a) * 16'(mif.mult_b);
                end
            end
        end
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] exp_of(input vec_t v);
`ifdef RGBW_SCALE_ROUND_EN
        return v.exp_round;
`else
        return v.exp_trunc;
`endif
    endfunction

    function automatic logic [31:0] outs();
        return {red_out, green_out, blue_out, white_out};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] v_lint, input logic [7:0] v_r,
                                  input logic [7:0] v_g, input logic [7:0] v_b,
                                  input logic [7:0] v_w, output int cyc, output int lds,
                                  output int ld_hi, output bit got_done);
        int ld0;
        bit en_at;
        lint     = v_lint;
        red_in   = v_r;
        green_in = v_g;
        blue_in  = v_b;
        white_in = v_w;
        ld0      = ld_count;
        start    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            if (clk_half) break;
        end
        #1;
        start    = 1'b0;
        cyc      = 1;
        ld_hi    = 0;
        got_done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (mif.mult_ld) ld_hi++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(posedge clk);
            en_at = clk_half;
            #1;
            if (en_at) cyc++;
        end
        lds = ld_count - ld0;
    endtask

    initial begin
        int  cyc;
        int  lds;
        int  ld_hi;
        bit  got_done;
        int  dones;
        bit  seen_err;
        logic [31:0] first_outs;
        logic [31:0] second_outs;

        vecs[0] = '{8'd128, 8'd200, 8'd100, 8'd50,  8'd255, 32'h6432197F, 32'h64321980, 13, 4};
        vecs[1] = '{8'd255, 8'd1,   8'd2,   8'd3,   8'd4,   32'h01020304, 32'h01020304, 2,  0};
        vecs[2] = '{8'd0,   8'd9,   8'd8,   8'd7,   8'd6,   32'h00000000, 32'h00000000, 2,  0};
        vecs[3] = '{8'd64,  8'd255, 8'd128, 8'd1,   8'd0,   32'h3F200000, 32'h40200000, 13, 4};
        vecs[4] = '{8'd254, 8'd255, 8'd255, 8'd255, 8'd255, 32'hFDFDFDFD, 32'hFDFDFDFD, 13, 4};
        vecs[5] = '{8'd1,   8'd255, 8'd200, 8'd0,   8'd128, 32'h00000000, 32'h01010001, 13, 4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_outs", outs(), 32'h0);
        check_output("reset_flags", {29'd0, busy, done, err}, 32'h0);
        check_output("reset_mult", {15'd0, mif.mult_ld, mif.mult_a, mif.mult_b}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single runs from the vector table
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].lint, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].w,
                           cyc, lds, ld_hi, got_done);
            check_output($sformatf("v%0d_done_seen", i), {31'd0, got_done}, 32'd1);
            check_output($sformatf("v%0d_done_cycle", i), cyc, vecs[i].exp_cyc);
            check_output($sformatf("v%0d_ld_count", i), lds, vecs[i].exp_lds);
            check_output($sformatf("v%0d_outs", i), outs(), exp_of(vecs[i]));
            check_output($sformatf("v%0d_busy_err", i), {30'd0, busy, err}, 32'd0);
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Start held during a run with inputs changed mid-run: one automatic rerun
        lint = vecs[0].lint; red_in = vecs[0].r; green_in = vecs[0].g;
        blue_in = vecs[0].b; white_in = vecs[0].w;
        start = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        lint = vecs[3].lint; red_in = vecs[3].r; green_in = vecs[3].g;
        blue_in = vecs[3].b; white_in = vecs[3].w;
        start = 1'b0;
        dones = 0;
        first_outs = 32'h0;
        second_outs = 32'h0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (dones == 1) first_outs = outs();
                else if (dones == 2) second_outs = outs();
            end
        end
        check_output("pend_done_count", dones, 32'd2);
        check_output("pend_first_outs", first_outs, exp_of(vecs[0]));
        check_output("pend_second_outs", second_outs, exp_of(vecs[3]));

        // Multiplier never answers the green load: timeout abort
        mute_at = ld_count + 2;
        lint = vecs[1].lint; red_in = 8'd77; green_in = 8'd66;
        blue_in = 8'd55; white_in = 8'd44;
        lint = 8'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        dones = 0;
        seen_err = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) dones++;
            if (err) begin
                seen_err = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        mute_at = -1;
        check_output("tmo_err_seen", {31'd0, seen_err}, 32'd1);
        check_output("tmo_err_cycle", cyc, 32'd69);
        check_output("tmo_no_done", dones, 32'd0);
        check_output("tmo_busy", {31'd0, busy}, 32'd0);
        check_output("tmo_outs_kept", outs(), exp_of(vecs[3]));
        repeat (3) @(posedge clk);
        #1;
        check_output("tmo_err_sticky", {31'd0, err}, 32'd1);

        // Clock enable toggling 1/0: same results in enabled-cycle terms
        @(negedge clk);
        toggle_en = 1'b1;
        apply_stimulus(vecs[0].lint, vecs[0].r, vecs[0].g, vecs[0].b, vecs[0].w,
                       cyc, lds, ld_hi, got_done);
        check_output("tog_done_seen", {31'd0, got_done}, 32'd1);
        check_output("tog_done_cycle", cyc, 32'd13);
        check_output("tog_ld_count", lds, 32'd4);
        check_output("tog_ld_high_cycles", ld_hi, 32'd8);
        check_output("tog_outs", outs(), exp_of(vecs[0]));
        check_output("tog_err_cleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        toggle_en = 1'b0;
        #1;
        clk_half = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted while waiting on the blue channel
        lint = vecs[3].lint; red_in = vecs[3].r; green_in = vecs[3].g;
        blue_in = vecs[3].b; white_in = vecs[3].w;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check_output("rst_mid_busy", {31'd0, busy}, 32'd1);
        check_output("rst_mid_mult_a", mif.mult_a, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_output("rst_async_outs", outs(), 32'h0);
        check_output("rst_async_flags", {29'd0, busy, done, err}, 32'h0);
        check_output("rst_async_mult", {15'd0, mif.mult_ld, mif.mult_a, mif.mult_b}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(vecs[0].lint, vecs[0].r, vecs[0].g, vecs[0].b, vecs[0].w,
                       cyc, lds, ld_hi, got_done);
        check_output("rst_rerun_done_seen", {31'd0, got_done}, 32'd1);
        check_output("rst_rerun_done_cycle", cyc, 32'd13);
        check_output("rst_rerun_outs", outs(), exp_of(vecs[0]));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
